// File: rtl/register_file_mp.sv
`default_nettype none
// ============================================================================
// Module      : register_file_mp
// Description : Multi-port register file with optional write-to-read bypass
//               and a per-register pending scoreboard for decode stalls.
// Revision    : 1.0 - initial release
// ============================================================================
module register_file_mp #(
   parameter int XLEN     = 32,
   parameter int NREGS    = 32,
   parameter int NUM_RD   = 2,
   parameter int NUM_WR   = 2,
   parameter int BYPASS   = 1,
   parameter int ZERO_REG = 1,
   localparam int AW      = $clog2(NREGS)
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [NUM_RD*AW-1:0]     rs_addr,
   output logic [NUM_RD*XLEN-1:0]   rs_data,
   output logic [NUM_RD-1:0]        rs_pending,
   input  logic [NUM_WR-1:0]        wr_en,
   input  logic [NUM_WR*AW-1:0]     wr_addr,
   input  logic [NUM_WR*XLEN-1:0]   wr_data,
   input  logic                     mark_en,
   input  logic [AW-1:0]            mark_addr,
   output logic                     any_pending,
   output logic [NREGS*XLEN-1:0]    debug_registers
);

   logic [XLEN-1:0]   r_regs [NREGS];
   logic [NREGS-1:0]  r_pending;
   logic [NUM_WR-1:0] w_wr_ok;
   logic [NUM_WR-1:0] w_wr_live;
   logic              w_mark_ok;

   generate
      for (genvar w = 0; w < NUM_WR; w++) begin : g_wr
         assign w_wr_ok[w] = wr_en[w] &&
                             !((ZERO_REG != 0) && (wr_addr[w*AW +: AW] == '0));
      end
   endgenerate

   // A write in a reset cycle never lands, so it must not be bypassed either.
   assign w_wr_live = w_wr_ok & {NUM_WR{reset}};
   assign w_mark_ok = mark_en && !((ZERO_REG != 0) && (mark_addr == '0));

   // Later assignments win: higher write ports over lower, mark over write-clear.
   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int r = 0; r < NREGS; r++) begin
            r_regs[r] <= '0;
         end
         r_pending <= '0;
      end else begin
         for (int w = 0; w < NUM_WR; w++) begin
            if (w_wr_ok[w]) begin
               r_regs[wr_addr[w*AW +: AW]]    <= wr_data[w*XLEN +: XLEN];
               r_pending[wr_addr[w*AW +: AW]] <= 1'b0;
            end
         end
         if (w_mark_ok) begin
            r_pending[mark_addr] <= 1'b1;
         end
      end
   end

   generate
      for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
         logic [AW-1:0]   w_ra;
         logic [XLEN-1:0] w_rd_data;
         logic            w_rd_pend;

         assign w_ra = rs_addr[i*AW +: AW];

         always_comb begin
            w_rd_data = r_regs[w_ra];
            w_rd_pend = r_pending[w_ra];
            if (BYPASS != 0) begin
               for (int w = 0; w < NUM_WR; w++) begin
                  if (w_wr_live[w] && (wr_addr[w*AW +: AW] == w_ra)) begin
                     w_rd_data = wr_data[w*XLEN +: XLEN];
                     w_rd_pend = 1'b0;
                  end
               end
            end
            if ((ZERO_REG != 0) && (w_ra == '0)) begin
               w_rd_data = '0;
               w_rd_pend = 1'b0;
            end
         end

         assign rs_data[i*XLEN +: XLEN] = w_rd_data;
         assign rs_pending[i]           = w_rd_pend;
      end

      for (genvar r = 0; r < NREGS; r++) begin : g_dbg
         assign debug_registers[r*XLEN +: XLEN] = r_regs[r];
      end
   endgenerate

   assign any_pending = |r_pending;

endmodule
`default_nettype wire

// File: tb/tb_register_file_mp.sv
`default_nettype none
// ============================================================================
// Module      : tb_register_file_mp
// Description : Self-checking bench for register_file_mp (bypass and no-bypass).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_register_file_mp;

   localparam int XLEN  = 32;
   localparam int NREGS = 32;
   localparam int AW    = 5;
   localparam int NRD   = 2;
   localparam int NWR   = 2;

   logic                   clk = 1'b0;
   logic                   reset;
   logic [NRD*AW-1:0]      rs_addr;
   logic [NWR-1:0]         wr_en;
   logic [NWR*AW-1:0]      wr_addr;
   logic [NWR*XLEN-1:0]    wr_data;
   logic                   mark_en;
   logic [AW-1:0]          mark_addr;

   logic [NRD*XLEN-1:0]    rd_b,  rd_n;
   logic [NRD-1:0]         pd_b,  pd_n;
   logic                   any_b, any_n;
   logic [NREGS*XLEN-1:0]  dbg_b, dbg_n;

   always #5 clk = ~clk;

   register_file_mp #(.BYPASS(1)) dut (
      .clk(clk), .reset(reset), .rs_addr(rs_addr), .rs_data(rd_b),
      .rs_pending(pd_b), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .mark_en(mark_en), .mark_addr(mark_addr), .any_pending(any_b),
      .debug_registers(dbg_b)
   );

   register_file_mp #(.BYPASS(0)) dut_nb (
      .clk(clk), .reset(reset), .rs_addr(rs_addr), .rs_data(rd_n),
      .rs_pending(pd_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .mark_en(mark_en), .mark_addr(mark_addr), .any_pending(any_n),
      .debug_registers(dbg_n)
   );

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: architectural state plus read rules.
   logic [31:0] m_reg  [NREGS];
   bit          m_pend [NREGS];

   function automatic logic [31:0] m_data(input int a, input bit byp);
      if (a == 0) return 32'h0;
      if (byp && reset) begin
         for (int w = NWR-1; w >= 0; w--)
            if (wr_en[w] && int'(wr_addr[w*AW +: AW]) == a) return wr_data[w*XLEN +: XLEN];
      end
      return m_reg[a];
   endfunction

   function automatic bit m_pnd(input int a, input bit byp);
      if (a == 0) return 1'b0;
      if (byp && reset) begin
         for (int w = 0; w < NWR; w++)
            if (wr_en[w] && int'(wr_addr[w*AW +: AW]) == a) return 1'b0;
      end
      return m_pend[a];
   endfunction

   function automatic bit m_any();
      for (int r = 0; r < NREGS; r++) if (m_pend[r]) return 1'b1;
      return 1'b0;
   endfunction

   task automatic model_edge();
      int a;
      if (!reset) begin
         for (int r = 0; r < NREGS; r++) begin
            m_reg[r]  = 32'h0;
            m_pend[r] = 1'b0;
         end
      end else begin
         for (int w = 0; w < NWR; w++) begin
            a = int'(wr_addr[w*AW +: AW]);
            if (wr_en[w] && a != 0) begin
               m_reg[a]  = wr_data[w*XLEN +: XLEN];
               m_pend[a] = 1'b0;
            end
         end
         if (mark_en && mark_addr != 0) m_pend[mark_addr] = 1'b1;
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic drive(input bit rn, input bit [1:0] we, input bit [4:0] wa0, input bit [31:0] wd0,
                        input bit [4:0] wa1, input bit [31:0] wd1, input bit me, input bit [4:0] ma,
                        input bit [4:0] ra0, input bit [4:0] ra1);
      reset     = rn;
      wr_en     = we;
      wr_addr   = {wa1, wa0};
      wr_data   = {wd1, wd0};
      mark_en   = me;
      mark_addr = ma;
      rs_addr   = {ra1, ra0};
   endtask

   typedef struct packed {
      bit        rn;
      bit [1:0]  we;
      bit [4:0]  wa0;
      bit [31:0] wd0;
      bit [4:0]  wa1;
      bit [31:0] wd1;
      bit        me;
      bit [4:0]  ma;
      bit [4:0]  ra0;
      bit [4:0]  ra1;
      bit [31:0] d0;
      bit [31:0] d1;
      bit        p0;
      bit        p1;
      bit        any;
   } vec_t;

   vec_t tbl [19];

   initial begin
      // Directed rows for the bypass build; each row's outputs are checked before its edge.
      tbl[0]  = '{1'b1, 2'b01, 5'd5, 32'h12345678, 5'd0, 32'h0, 1'b0, 5'd0, 5'd5, 5'd5, 32'h12345678, 32'h12345678, 1'b0, 1'b0, 1'b0};
      tbl[1]  = '{1'b0, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd5, 5'd0, 32'h12345678, 32'h0, 1'b0, 1'b0, 1'b0};
      tbl[2]  = '{1'b0, 2'b01, 5'd6, 32'h00000999, 5'd0, 32'h0, 1'b1, 5'd6, 5'd5, 5'd5, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0};
      tbl[3]  = '{1'b1, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd5, 5'd6, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0};
      tbl[4]  = '{1'b1, 2'b01, 5'd1, 32'hDEADBEEF, 5'd0, 32'h0, 1'b0, 5'd0, 5'd9, 5'd9, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0};
      tbl[5]  = '{1'b1, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd1, 5'd2, 32'hDEADBEEF, 32'h0, 1'b0, 1'b0, 1'b0};
      tbl[6]  = '{1'b1, 2'b11, 5'd3, 32'hAAAA0000, 5'd3, 32'h0000BBBB, 1'b0, 5'd0, 5'd3, 5'd3, 32'h0000BBBB, 32'h0000BBBB, 1'b0, 1'b0, 1'b0};
      tbl[7]  = '{1'b1, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd3, 5'd1, 32'h0000BBBB, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0};
      tbl[8]  = '{1'b1, 2'b11, 5'd0, 32'hFFFFFFFF, 5'd0, 32'hFFFFFFFF, 1'b1, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0};
      tbl[9]  = '{1'b1, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0};
      tbl[10] = '{1'b1, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b1, 5'd7, 5'd7, 5'd1, 32'h0, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0};
      tbl[11] = '{1'b1, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd7, 5'd1, 32'h0, 32'hDEADBEEF, 1'b1, 1'b0, 1'b1};
      tbl[12] = '{1'b1, 2'b01, 5'd7, 32'h00000055, 5'd0, 32'h0, 1'b0, 5'd0, 5'd7, 5'd7, 32'h55, 32'h55, 1'b0, 1'b0, 1'b1};
      tbl[13] = '{1'b1, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd7, 5'd3, 32'h55, 32'h0000BBBB, 1'b0, 1'b0, 1'b0};
      tbl[14] = '{1'b1, 2'b10, 5'd0, 32'h0, 5'd7, 32'h00000066, 1'b1, 5'd7, 5'd7, 5'd7, 32'h66, 32'h66, 1'b0, 1'b0, 1'b0};
      tbl[15] = '{1'b1, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd7, 5'd7, 32'h66, 32'h66, 1'b1, 1'b1, 1'b1};
      tbl[16] = '{1'b1, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b1, 5'd7, 5'd7, 5'd0, 32'h66, 32'h0, 1'b1, 1'b0, 1'b1};
      tbl[17] = '{1'b1, 2'b10, 5'd0, 32'h0, 5'd7, 32'h00000077, 1'b0, 5'd0, 5'd7, 5'd7, 32'h77, 32'h77, 1'b0, 1'b0, 1'b1};
      tbl[18] = '{1'b1, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd7, 5'd3, 32'h77, 32'h0000BBBB, 1'b0, 1'b0, 1'b0};

      drive(1'b0, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0);
      for (int r = 0; r < NREGS; r++) begin
         m_reg[r]  = 32'h0;
         m_pend[r] = 1'b0;
      end
      @(posedge clk); #1;
      step();
      step();

      for (int i = 0; i < 19; i++) begin
         drive(tbl[i].rn, tbl[i].we, tbl[i].wa0, tbl[i].wd0, tbl[i].wa1, tbl[i].wd1,
               tbl[i].me, tbl[i].ma, tbl[i].ra0, tbl[i].ra1);
         #2;
         check($sformatf("vec%0d rd0_data", i), rd_b[31:0],  tbl[i].d0);
         check($sformatf("vec%0d rd1_data", i), rd_b[63:32], tbl[i].d1);
         check($sformatf("vec%0d rd0_pend", i), {31'h0, pd_b[0]}, {31'h0, tbl[i].p0});
         check($sformatf("vec%0d rd1_pend", i), {31'h0, pd_b[1]}, {31'h0, tbl[i].p1});
         check($sformatf("vec%0d any_pend", i), {31'h0, any_b},   {31'h0, tbl[i].any});
         step();
      end

      // No-bypass build: new data only after the edge.
      drive(1'b1, 2'b01, 5'd4, 32'h1, 5'd0, 32'h0, 1'b0, 5'd0, 5'd4, 5'd4);
      #2;
      check("nobyp same_cycle", rd_n[31:0], 32'h0);
      check("byp same_cycle",   rd_b[31:0], 32'h1);
      step();
      drive(1'b1, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd4, 5'd4);
      #2;
      check("nobyp next_cycle", rd_n[31:0], 32'h1);
      step();

      // Randomised traffic against the model, addresses biased for collisions.
      for (int c = 0; c < 400; c++) begin
         bit [4:0] a [6];
         for (int k = 0; k < 6; k++)
            a[k] = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
         drive(($urandom_range(0, 29) != 0), 2'($urandom_range(0, 3)), a[0], $urandom,
               a[1], $urandom, ($urandom_range(0, 2) == 0), a[2], a[3], a[4]);
         #2;
         if (reset) begin
            for (int p = 0; p < NRD; p++) begin
               check($sformatf("rnd b rd%0d_data", p), rd_b[p*XLEN +: XLEN], m_data(int'(rs_addr[p*AW +: AW]), 1'b1));
               check($sformatf("rnd n rd%0d_data", p), rd_n[p*XLEN +: XLEN], m_data(int'(rs_addr[p*AW +: AW]), 1'b0));
               check($sformatf("rnd b rd%0d_pend", p), {31'h0, pd_b[p]}, {31'h0, m_pnd(int'(rs_addr[p*AW +: AW]), 1'b1)});
               check($sformatf("rnd n rd%0d_pend", p), {31'h0, pd_n[p]}, {31'h0, m_pnd(int'(rs_addr[p*AW +: AW]), 1'b0)});
            end
         end
         check("rnd b any_pend", {31'h0, any_b}, {31'h0, m_any()});
         check("rnd n any_pend", {31'h0, any_n}, {31'h0, m_any()});
         for (int r = 0; r < NREGS; r++) begin
            check($sformatf("rnd b dbg%0d", r), dbg_b[r*XLEN +: XLEN], m_reg[r]);
            check($sformatf("rnd n dbg%0d", r), dbg_n[r*XLEN +: XLEN], m_reg[r]);
         end
         step();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/register_file_mp.md
Name: register_file_mp

Overview:
- Parametrised multi-port successor to the single-write, dual-read register file.
- Configurable data width, register count, read-port count and write-port count.
- Optional same-cycle write-to-read bypass.
- Per-register pending scoreboard so the decode stage can stall on registers whose producers (e.g. loads, multi-cycle ops) have not written back yet.
- Sits between decode (reads, marks) and writeback (writes) in the RISC-V core.

Parameters:
XLEN, 32, data width of each register
NREGS, 32, number of architectural registers (power of 2, at least 2)
AW, $clog2(NREGS), address width (derived, not overridden)
NUM_RD, 2, number of read ports
NUM_WR, 2, number of write ports
BYPASS, 1, 1 = read of a register written this cycle returns the new data; 0 = returns the stored value
ZERO_REG, 1, 1 = register 0 hardwired to zero, never written, never pending

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous reset, active-low
rs_addr  in  NUM_RD*AW  read addresses; port i in slice [i*AW +: AW]
rs_data  out  NUM_RD*XLEN  read data; port i in slice [i*XLEN +: XLEN]
rs_pending  out  NUM_RD  pending bit of the register addressed by each read port
wr_en  in  NUM_WR  per-port write enable
wr_addr  in  NUM_WR*AW  write addresses
wr_data  in  NUM_WR*XLEN  write data
mark_en  in  1  set the pending bit of mark_addr at the next edge
mark_addr  in  AW  register whose pending bit is set
any_pending  out  1  OR of all pending bits
debug_registers  out  NREGS*XLEN  flat view of all stored registers (register r in [r*XLEN +: XLEN])

Behaviour:
- Reset: reset sampled low at a rising edge.
  - All registers and all pending bits are cleared to 0.
  - Takes priority over wr_en and mark_en in that same cycle.
  - After reset: rs_data = 0, rs_pending = 0, any_pending = 0.
- Reset mid-operation: a write or mark presented in a reset cycle is discarded entirely.
- Writes:
  - On the rising edge, each port with wr_en=1 updates register wr_addr.
  - Two or more enabled ports with the same address: the highest-index port wins.
- Register 0 (ZERO_REG=1): writes are ignored; reads always return 0; pending is never set and rs_pending is always 0.
- Reads:
  - Combinational, zero-cycle latency from rs_addr to rs_data and rs_pending.
  - Any number of read ports may address the same register.
- Bypass:
  - BYPASS=1: if any wr_en port targets a read port's address this cycle (excluding reg 0 when ZERO_REG=1), rs_data returns that port's wr_data. Highest-index matching port wins.
  - BYPASS=0: rs_data returns the stored value; new data is visible the cycle after the edge.
- Scoreboard:
  - mark_en=1 sets pending[mark_addr] at the edge.
  - An enabled write to register r clears pending[r] at the edge.
  - Mark and write to the same register in the same cycle: pending ends set, because the mark represents a newer producer.
  - Marking an already-pending register keeps it pending; there is no count.
- rs_pending bypass:
  - With BYPASS=1, rs_pending is forced to 0 when the same-cycle write bypass hits.
  - A same-cycle mark does not affect rs_pending until the next cycle.
- Registers never hold X after reset; no other latency applies.

Test Plan:
- Reset low for 2 edges after writing 0x12345678 to x5 -> rs_data for x5 = 0 and any_pending = 0 after release.
- Write x1 = 0xDEADBEEF via port 0, then read x1 on rd0 and x2 on rd1 next cycle -> rd0 = 0xDEADBEEF, rd1 = 0x00000000.
- Same cycle: port 0 writes x3 = 0xAAAA0000, port 1 writes x3 = 0x0000BBBB -> x3 = 0x0000BBBB; with BYPASS=1, reading x3 in that cycle also gives 0x0000BBBB.
- Write x0 = 0xFFFFFFFF on both ports and mark_addr = 0 -> x0 reads 0, rs_pending = 0, any_pending = 0.
- Scoreboard sequence:
  - Mark x7 -> next cycle rs_pending = 1 for x7 and any_pending = 1.
  - Write x7 = 0x55 -> rs_pending = 0 in that same cycle (bypass); pending bit cleared after the edge.
  - Mark and write x7 together -> x7 stays pending.
- BYPASS=0 build: write x4 = 0x1 -> the same-cycle read of x4 returns the old value 0; the next cycle returns 0x1.
